// File: rtl/fetch_utlb_stage.sv
`timescale 1ns/1ps
// Instruction-fetch request stage: kseg0/1 bypass plus an N-entry fully associative
// micro-TLB refilled round-robin from the shared TLB on a miss.
module fetch_utlb_stage #(
    parameter int unsigned UTLB_ENTRIES = 4,
    parameter int unsigned CACHE_FAULTS = 1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_cache,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        tlb_write,
    output logic [31:0] tlb_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_invalid,
    input  logic [2:0]  tlb_cattr,
    input  logic [31:0] status,
    input  logic [2:0]  config_k0,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        commit_i,
    output logic [31:0] perfcnt_fetch_waitreq,
    output logic [31:0] perfcnt_utlb_miss
);

    localparam int unsigned IdxW      = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;
    localparam int unsigned StatusUm  = 4;
    localparam int unsigned StatusExl = 1;
    localparam logic [4:0]  ExcAdel   = 5'd4;
    localparam logic [4:0]  ExcTlbl   = 5'd2;

    typedef enum logic [1:0] {
        StCheck = 2'd0,
        StQuery = 2'd1,
        StReq   = 2'd2
    } qstate_e;

    qstate_e qstate_q, qstate_d;

    logic [UTLB_ENTRIES-1:0] ent_valid_q;
    logic [19:0]             ent_vpn_q   [UTLB_ENTRIES];
    logic [19:0]             ent_pfn_q   [UTLB_ENTRIES];
    logic                    ent_miss_q  [UTLB_ENTRIES];
    logic                    ent_inv_q   [UTLB_ENTRIES];
    logic [2:0]              ent_cattr_q [UTLB_ENTRIES];
    logic [IdxW-1:0]         rr_q;

    logic [19:0] res_pfn_q;
    logic        res_miss_q, res_inv_q;
    logic [2:0]  res_cattr_q;
    logic [31:0] pc_save_q;

    logic        valid_q, cancelled_q, exc_q, exc_miss_q;
    logic [31:0] pc_q, waitreq_q, utlb_miss_q;
    logic [4:0]  exccode_q;

    logic        kseg01, kseg0, kernel, adel;
    logic        hit, hit_miss, hit_inv;
    logic [19:0] hit_pfn;
    logic [2:0]  hit_cattr;
    logic        if_req_exc, exc_miss_d, install;
    logic        unused_ok;

    assign kseg01 = (pc_i[31:30] == 2'b10);
    assign kseg0  = (pc_i[31:29] == 3'b100);
    assign kernel = !status[StatusUm] || status[StatusExl];
    assign adel   = (pc_i[1:0] != 2'b00) || (pc_i[31] && !kernel);

    // Entries are unique per VPN, so OR-combining the matching fields selects the hit.
    always_comb begin
        hit       = 1'b0;
        hit_miss  = 1'b0;
        hit_inv   = 1'b0;
        hit_pfn   = '0;
        hit_cattr = '0;
        for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
            if (ent_valid_q[i] && (ent_vpn_q[i] == pc_i[31:12])) begin
                hit       = 1'b1;
                hit_miss  = hit_miss | ent_miss_q[i];
                hit_inv   = hit_inv | ent_inv_q[i];
                hit_pfn   = hit_pfn | ent_pfn_q[i];
                hit_cattr = hit_cattr | ent_cattr_q[i];
            end
        end
    end

    always_comb begin
        qstate_d   = qstate_q;
        if_req_exc = 1'b0;
        exc_miss_d = 1'b0;
        unique case (qstate_q)
            StCheck: begin
                if_req_exc = adel || (hit && (hit_miss || hit_inv));
                exc_miss_d = hit && hit_miss;
                if (!(kseg01 || hit || !valid_i || !ready_i)) begin
                    qstate_d = StQuery;
                end
            end
            StQuery: qstate_d = StReq;
            StReq: begin
                if_req_exc = res_miss_q || res_inv_q;
                exc_miss_d = res_miss_q;
                if (inst_addr_ok || if_req_exc) begin
                    qstate_d = StCheck;
                end
            end
            default: qstate_d = StCheck;
        endcase
        if (commit_i) begin
            qstate_d = StCheck;
        end
    end

    always_comb begin
        inst_req = valid_i && ready_i && !if_req_exc &&
                   (((qstate_q == StCheck) && (kseg01 || hit)) || (qstate_q == StReq));
        if (qstate_q == StReq) begin
            inst_addr  = {res_pfn_q, pc_save_q[11:0]};
            inst_cache = res_cattr_q[0];
        end else if (kseg01) begin
            inst_addr  = {3'b000, pc_i[28:0]};
            inst_cache = kseg0 && config_k0[0];
        end else begin
            inst_addr  = {hit_pfn, pc_i[11:0]};
            inst_cache = hit_cattr[0];
        end
    end

    assign ready_o   = ready_i && (inst_addr_ok || if_req_exc);
    assign tlb_vaddr = pc_save_q;
    assign install   = (CACHE_FAULTS != 0) || !(tlb_miss || tlb_invalid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qstate_q    <= StCheck;
            ent_valid_q <= '0;
            for (int i = 0; i < int'(UTLB_ENTRIES); i++) begin
                ent_vpn_q[i]   <= '0;
                ent_pfn_q[i]   <= '0;
                ent_miss_q[i]  <= 1'b0;
                ent_inv_q[i]   <= 1'b0;
                ent_cattr_q[i] <= '0;
            end
            rr_q        <= '0;
            res_pfn_q   <= '0;
            res_miss_q  <= 1'b0;
            res_inv_q   <= 1'b0;
            res_cattr_q <= '0;
            pc_save_q   <= '0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            cancelled_q <= 1'b0;
            exc_q       <= 1'b0;
            exc_miss_q  <= 1'b0;
            exccode_q   <= '0;
            waitreq_q   <= '0;
            utlb_miss_q <= '0;
        end else begin
            qstate_q <= qstate_d;
            if (qstate_q == StCheck) begin
                pc_save_q <= pc_i;
            end
            if (qstate_q == StQuery) begin
                res_pfn_q   <= tlb_paddr[31:12];
                res_miss_q  <= tlb_miss;
                res_inv_q   <= tlb_invalid;
                res_cattr_q <= tlb_cattr;
                if (install) begin
                    ent_valid_q[rr_q] <= 1'b1;
                    ent_vpn_q[rr_q]   <= pc_save_q[31:12];
                    ent_pfn_q[rr_q]   <= tlb_paddr[31:12];
                    ent_miss_q[rr_q]  <= tlb_miss;
                    ent_inv_q[rr_q]   <= tlb_invalid;
                    ent_cattr_q[rr_q] <= tlb_cattr;
                    rr_q <= (rr_q == IdxW'(UTLB_ENTRIES - 1)) ? '0 : rr_q + IdxW'(1);
                end
            end
            // A flush overrides an install landing in the same cycle.
            if (tlb_write || commit_i) begin
                ent_valid_q <= '0;
            end
            if (ready_i) begin
                valid_q     <= (valid_i && inst_addr_ok) || if_req_exc;
                pc_q        <= (qstate_q == StCheck) ? pc_i : pc_save_q;
                cancelled_q <= commit_i;
                exc_q       <= if_req_exc;
                exc_miss_q  <= exc_miss_d;
                exccode_q   <= adel ? ExcAdel : ExcTlbl;
            end
            if (inst_req && !inst_addr_ok) begin
                waitreq_q <= waitreq_q + 32'd1;
            end
            if ((qstate_q == StCheck) && (qstate_d == StQuery)) begin
                utlb_miss_q <= utlb_miss_q + 32'd1;
            end
        end
    end

    assign valid_o               = valid_q;
    assign pc_o                  = pc_q;
    assign cancelled_o           = cancelled_q;
    assign exc_o                 = exc_q;
    assign exc_miss_o            = exc_miss_q;
    assign exccode_o             = exccode_q;
    assign perfcnt_fetch_waitreq = waitreq_q;
    assign perfcnt_utlb_miss     = utlb_miss_q;

    assign unused_ok = ^{tlb_paddr[11:0], status[31:5], status[3:2], status[0],
                         config_k0[2:1], hit_cattr[2:1], res_cattr_q[2:1]};

endmodule

// File: tb/tb_fetch_utlb_stage.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_utlb_stage: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural model of the fetch stage and shared TLB.
module tb_fetch_utlb_stage;

    localparam int unsigned UTLB = 4;
    localparam int unsigned CF   = 1;

    typedef struct packed {
        logic [19:0] pfn;
        logic        miss;
        logic        inv;
        logic [2:0]  cattr;
    } tlbres_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache, inst_addr_ok, tlb_write;
    logic [31:0] inst_addr, tlb_vaddr, tlb_paddr, status, pc_i, pc_o;
    logic        tlb_miss, tlb_invalid;
    logic [2:0]  tlb_cattr, config_k0;
    logic        valid_i, ready_o, ready_i, valid_o, cancelled_o, exc_o, exc_miss_o, commit_i;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_fetch_waitreq, perfcnt_utlb_miss;
    logic        accept;
    logic [7:0]  gen;
    tlbres_t     tr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared-TLB stand-in: fixed page table whose PFNs shift on every TLB write.
    function automatic tlbres_t tlb_fn(input logic [19:0] vpn, input logic [7:0] g);
        tlbres_t r;
        r.miss  = (vpn == 20'h00800) || (vpn[3:0] == 4'hE);
        r.inv   = (vpn[3:0] == 4'hD);
        r.pfn   = ((vpn == 20'h00400) ? 20'h12345 : (vpn ^ 20'hABCDE)) ^ {g, 12'h000};
        r.cattr = (vpn == 20'h00400) ? 3'd3 : vpn[6:4];
        return r;
    endfunction

    assign tr           = tlb_fn(tlb_vaddr[31:12], gen);
    assign tlb_paddr    = {tr.pfn, 12'h000};
    assign tlb_miss     = tr.miss;
    assign tlb_invalid  = tr.inv;
    assign tlb_cattr    = tr.cattr;
    assign inst_addr_ok = inst_req && accept;

    fetch_utlb_stage #(.UTLB_ENTRIES(UTLB), .CACHE_FAULTS(CF)) dut (
        .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_cache(inst_cache),
        .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .tlb_write(tlb_write),
        .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss),
        .tlb_invalid(tlb_invalid), .tlb_cattr(tlb_cattr), .status(status),
        .config_k0(config_k0), .valid_i(valid_i), .pc_i(pc_i), .ready_o(ready_o),
        .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .cancelled_o(cancelled_o),
        .exc_o(exc_o), .exc_miss_o(exc_miss_o), .exccode_o(exccode_o), .commit_i(commit_i),
        .perfcnt_fetch_waitreq(perfcnt_fetch_waitreq), .perfcnt_utlb_miss(perfcnt_utlb_miss)
    );

    // Reference model state: 0 = checking, 1 = querying shared TLB, 2 = requesting.
    int          m_st, m_rr;
    bit          m_v   [UTLB];
    logic [19:0] m_vpn [UTLB];
    tlbres_t     m_ent [UTLB];
    tlbres_t     m_res;
    logic [31:0] m_pc_save, m_pc_o, m_wait, m_umiss;
    logic        m_valid_o, m_canc, m_exc, m_xmiss;
    logic [4:0]  m_code;
    logic        e_req, e_cache, e_ok, e_ready, e_exc, e_xmiss, e_adel, e_hit, e_kseg01;
    logic [31:0] e_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rr = 0; m_res = '0; m_pc_save = '0;
        for (int i = 0; i < int'(UTLB); i++) m_v[i] = 1'b0;
        m_valid_o = 0; m_pc_o = '0; m_canc = 0; m_exc = 0; m_xmiss = 0; m_code = '0;
        m_wait = '0; m_umiss = '0;
    endtask

    task automatic model_comb();
        int hi;
        logic kernel;
        e_kseg01 = (pc_i[31:30] == 2'b10);
        kernel   = !status[4] || status[1];
        e_adel   = (pc_i[1:0] != 2'b00) || (pc_i[31] && !kernel);
        e_hit = 1'b0; hi = 0;
        for (int i = 0; i < int'(UTLB); i++)
            if (m_v[i] && m_vpn[i] == pc_i[31:12]) begin e_hit = 1'b1; hi = i; end
        e_exc = 1'b0; e_xmiss = 1'b0;
        if (m_st == 0) begin
            e_exc   = e_adel || (e_hit && (m_ent[hi].miss || m_ent[hi].inv));
            e_xmiss = e_hit && m_ent[hi].miss;
        end else if (m_st == 2) begin
            e_exc   = m_res.miss || m_res.inv;
            e_xmiss = m_res.miss;
        end
        e_req = valid_i && ready_i && !e_exc && ((m_st == 0 && (e_kseg01 || e_hit)) || m_st == 2);
        if (m_st == 2) begin
            e_addr = {m_res.pfn, m_pc_save[11:0]}; e_cache = m_res.cattr[0];
        end else if (e_kseg01) begin
            e_addr = pc_i & 32'h1FFF_FFFF; e_cache = (pc_i[29] == 1'b0) && config_k0[0];
        end else begin
            e_addr = {m_ent[hi].pfn, pc_i[11:0]}; e_cache = m_ent[hi].cattr[0];
        end
        e_ok    = e_req && accept;
        e_ready = ready_i && (e_ok || e_exc);
    endtask

    task automatic model_seq();
        int nst;
        tlbres_t t;
        nst = m_st;
        if (m_st == 0 && valid_i && ready_i && !e_kseg01 && !e_hit) nst = 1;
        else if (m_st == 1) nst = 2;
        else if (m_st == 2 && (e_ok || e_exc)) nst = 0;
        if (commit_i) nst = 0;
        if (m_st == 0 && nst == 1) m_umiss = m_umiss + 1;
        if (e_req && !e_ok) m_wait = m_wait + 1;
        if (m_st == 1) begin
            t = tlb_fn(m_pc_save[31:12], gen);
            m_res = t;
            if (CF != 0 || !(t.miss || t.inv)) begin
                m_v[m_rr] = 1'b1; m_vpn[m_rr] = m_pc_save[31:12]; m_ent[m_rr] = t;
                m_rr = (m_rr + 1) % int'(UTLB);
            end
        end
        if (tlb_write || commit_i)
            for (int i = 0; i < int'(UTLB); i++) m_v[i] = 1'b0;
        if (ready_i) begin
            m_valid_o = (valid_i && e_ok) || e_exc;
            m_pc_o    = (m_st == 0) ? pc_i : m_pc_save;
            m_canc    = commit_i;
            m_exc     = e_exc;
            m_xmiss   = e_xmiss;
            m_code    = e_adel ? 5'd4 : 5'd2;
        end
        if (m_st == 0) m_pc_save = pc_i;
        m_st = nst;
        if (tlb_write) gen = gen + 8'd1;
    endtask

    task automatic check_regs();
        chk("valid_o", 32'(valid_o), 32'(m_valid_o));
        chk("pc_o", pc_o, m_pc_o);
        chk("cancelled_o", 32'(cancelled_o), 32'(m_canc));
        chk("exc_o", 32'(exc_o), 32'(m_exc));
        chk("exc_miss_o", 32'(exc_miss_o), 32'(m_xmiss));
        chk("exccode_o", 32'(exccode_o), 32'(m_code));
        chk("perf_waitreq", perfcnt_fetch_waitreq, m_wait);
        chk("perf_utlb_miss", perfcnt_utlb_miss, m_umiss);
    endtask

    task automatic settle();
        #2;
        model_comb();
        chk("inst_req", 32'(inst_req), 32'(e_req));
        chk("ready_o", 32'(ready_o), 32'(e_ready));
        chk("tlb_vaddr", tlb_vaddr, m_pc_save);
        if (e_req) begin
            chk("inst_addr", inst_addr, e_addr);
            chk("inst_cache", 32'(inst_cache), 32'(e_cache));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_seq();
        check_regs();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic acc);
        bit done = 1'b0;
        valid_i = 1'b1; pc_i = pc; ready_i = 1'b1; accept = acc;
        for (int c = 0; c < 12 && !done; c++) begin
            settle();
            done = e_ready;
            tick();
        end
        if (!done) chk("fetch_timeout", 32'(done), 32'd1);
        valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base;
        logic [19:0] vpn;
        logic [11:0] off;
        logic        last_ready;
        int unsigned r;

        resetn = 1'b0; valid_i = 0; pc_i = '0; ready_i = 0; accept = 0;
        tlb_write = 0; commit_i = 0; status = '0; config_k0 = 3'd3; gen = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();
        resetn = 1'b1;

        // kseg1 boot fetch issues in the same cycle
        valid_i = 1; ready_i = 1; accept = 1; pc_i = 32'hBFC0_0000;
        settle();
        chk("boot_req", 32'(inst_req), 32'd1);
        chk("boot_addr", inst_addr, 32'h1FC0_0000);
        chk("boot_cache", 32'(inst_cache), 32'd0);
        tick();
        chk("boot_valid_o", 32'(valid_o), 32'd1);
        chk("boot_pc_o", pc_o, 32'hBFC0_0000);

        // micro-TLB miss, refill, then same-page hit
        pc_i = 32'h0040_0004;
        settle(); tick();
        settle();
        chk("query_vaddr", tlb_vaddr, 32'h0040_0004);
        tick();
        settle();
        chk("refill_req", 32'(inst_req), 32'd1);
        chk("refill_addr", inst_addr, 32'h1234_5004);
        chk("refill_cache", 32'(inst_cache), 32'd1);
        tick();
        pc_i = 32'h0040_0008;
        settle();
        chk("hit_req", 32'(inst_req), 32'd1);
        chk("hit_addr", inst_addr, 32'h1234_5008);
        tick();
        chk("hit_no_refill", perfcnt_utlb_miss, 32'd1);

        // five new pages then the first again: round-robin eviction
        base = m_umiss;
        for (int k = 0; k < 5; k++) fetch(32'h1000_0000 + 32'(k) * 32'h1000, 1'b1);
        fetch(32'h1000_0000, 1'b1);
        chk("evict_refills", perfcnt_utlb_miss, base + 32'd6);

        // shared-TLB refill miss, then cached fault, then address error on a hit page
        fetch(32'h0080_0000, 1'b1);
        chk("tlbmiss_exc", 32'(exc_o), 32'd1);
        chk("tlbmiss_miss", 32'(exc_miss_o), 32'd1);
        chk("tlbmiss_code", 32'(exccode_o), 32'd2);
        base = m_umiss;
        fetch(32'h0080_0000, 1'b1);
        chk("cached_fault_exc", 32'(exc_o), 32'd1);
        chk("cached_fault_norefill", perfcnt_utlb_miss, base);
        fetch(32'h0040_0000, 1'b1);
        fetch(32'h0040_0002, 1'b1);
        chk("adel_exc", 32'(exc_o), 32'd1);
        chk("adel_code", 32'(exccode_o), 32'd4);

        // TLB write flushes the micro-TLB
        tlb_write = 1; settle(); tick(); tlb_write = 0;
        base = m_umiss;
        fetch(32'h0040_0010, 1'b1);
        chk("tlbw_requery", perfcnt_utlb_miss, base + 32'd1);

        // commit while a request is stalled in REQ
        valid_i = 1; pc_i = 32'h0050_0000; accept = 0; ready_i = 1;
        settle(); tick(); settle(); tick(); settle(); tick();
        commit_i = 1; settle(); tick(); commit_i = 0;
        chk("commit_cancel", 32'(cancelled_o), 32'd1);
        settle();
        chk("commit_back_to_check", 32'(inst_req), 32'd0);
        tick();
        fetch(32'h0050_0000, 1'b1);

        // randomized traffic
        last_ready = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (!valid_i || last_ready) begin
                r   = $urandom_range(0, 19);
                vpn = 20'($urandom_range(0, 31));
                off = 12'($urandom_range(0, 1023) * 4);
                if (r == 0)      pc_i = 32'h8000_0000 | {vpn, off};
                else if (r == 1) pc_i = 32'hA000_0000 | {vpn, off};
                else if (r == 2) pc_i = {vpn, off} | 32'($urandom_range(1, 3));
                else             pc_i = {vpn, off};
            end
            valid_i   = ($urandom_range(0, 9) != 0);
            ready_i   = ($urandom_range(0, 4) != 0);
            accept    = ($urandom_range(0, 2) != 0);
            commit_i  = ($urandom_range(0, 39) == 0);
            tlb_write = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) status[4] = ~status[4];
            settle();
            last_ready = e_ready;
            tick();
        end
        commit_i = 0; tlb_write = 0; status = '0;

        // asynchronous reset while stalled in REQ
        valid_i = 1; pc_i = 32'h0060_0000; accept = 0; ready_i = 1;
        settle(); tick(); settle(); tick();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("rst_req", 32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        fetch(32'h0060_0000, 1'b1);
        chk("rst_entries_invalid", perfcnt_utlb_miss, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_utlb_stage.md
# fetch_utlb_stage

Instruction-fetch request stage with an N-entry fully associative instruction micro-TLB, replacing the single-entry translation cache of the current fetch front end. It sits between the PC generator and the instruction-memory request port, and ahead of the fetch-wait/decode register. It translates `pc_i` through kseg0/1 bypass or the micro-TLB, refilling misses from the shared TLB. It issues `inst_req` and forwards the PC, address errors and TLB exceptions downstream.

## Interface
- `UTLB_ENTRIES`, default 4: micro-TLB entries; power of two, 1..16.
- `CACHE_FAULTS`, default 1: 1 = refills with miss/invalid results are installed; 0 = faulting results are used once and not installed.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `inst_req` out 1: fetch request; `inst_cache` out 1: cacheable attribute; `inst_addr` out 32: physical address; `inst_addr_ok` in 1: request accepted.
- `tlb_write` in 1: TLB modified (TLBWI/TLBWR).
- `tlb_vaddr` out 32: TLB lookup address.
- `tlb_paddr` in 32, `tlb_miss` in 1, `tlb_invalid` in 1, `tlb_cattr` in 3: lookup result, valid the cycle after `tlb_vaddr` is presented.
- `status` in 32: CP0 Status (`STATUS_UM`, `STATUS_EXL` bits).
- `config_k0` in 3: Config.K0.
- `valid_i` in 1, `pc_i` in 32: upstream PC; `ready_o` out 1: PC consumed.
- `ready_i` in 1: downstream ready.
- `valid_o` out 1, `pc_o` out 32, `cancelled_o` out 1: downstream slot.
- `exc_o` out 1, `exc_miss_o` out 1 (TLB refill vs. invalid), `exccode_o` out 5.
- `commit_i` in 1: pipeline flush (exception/eret commit).
- `perfcnt_fetch_waitreq` out 32: stalled-request cycles; `perfcnt_utlb_miss` out 32: micro-TLB refills.

## Operation
- Segments: kseg01 = `pc_i[31:30]==2'b10`, kseg0 = `pc_i[31:29]==3'b100`, kernel = `!status[UM] || status[EXL]`.
- adel = `pc_i[1:0]!=0 || (pc_i[31] && !kernel)`.
- Entry: valid, vpn[19:0], pfn[19:0], miss, invalid, cattr[2:0]. Hit = valid && vpn==`pc_i[31:12]`; at most one entry hits.
- FSM `qstate`:
  - CHECK(0): if kseg01 or hit or !valid_i or !ready_i, stay CHECK; else go to QUERY.
  - QUERY(1): always go to REQ.
  - REQ(2): go to CHECK on `inst_addr_ok` or on a fault.
  - `commit_i` forces CHECK next cycle from any state.
- `pc_save` <= `pc_i` whenever in CHECK; held otherwise. `tlb_vaddr = pc_save`.
- In QUERY, the result is captured into the result register `res_*`. If `CACHE_FAULTS` or the result is not faulting, it is also written to the entry at round-robin pointer `rr`, and `rr` advances modulo `UTLB_ENTRIES`.
- Any cycle with `tlb_write || commit_i` clears all valid bits. Clear wins over a same-cycle install; `res_*` is still written and used by REQ.
- Fault (`if_req_exc`):
  - CHECK: adel, or a hit entry with miss|invalid.
  - REQ: `res_miss|res_invalid`.
- Request: `inst_req = valid_i && ready_i && !if_req_exc && (CHECK&&(kseg01||hit) || REQ)`.
- Address:
  - CHECK & kseg01: `{3'b0,pc_i[28:0]}`, `inst_cache = kseg0 && config_k0[0]`.
  - CHECK & hit: `{pfn,pc_i[11:0]}`, `inst_cache = cattr[0]`.
  - REQ: `{res_pfn,pc_save[11:0]}`, `inst_cache = res_cattr[0]`.
- `ready_o = ready_i && (inst_addr_ok || if_req_exc)`.
- On `ready_i`, registered outputs update:
  - `valid_o <= valid_i&&inst_addr_ok || if_req_exc`
  - `pc_o <=` CHECK ? `pc_i` : `pc_save`
  - `cancelled_o <= commit_i`
  - `exc_o <= if_req_exc`
  - `exc_miss_o <=` the miss bit of the faulting hit entry / result
  - `exccode_o <=` adel ? EXC_ADEL(4) : EXC_TLBL(2)
- Counters: `perfcnt_fetch_waitreq` +1 when `inst_req && !inst_addr_ok`; `perfcnt_utlb_miss` +1 on each CHECK→QUERY transition. Both wrap at 2^32.

## Timing
- Reset (async): qstate=CHECK, all entries invalid, `rr`=0, `res_*`=0, `pc_save`=0. All registered outputs 0; both counters 0.
- kseg01 or micro-TLB hit: `inst_req` in the same cycle as `valid_i`, no added latency.
- Micro-TLB miss: CHECK at cycle t, QUERY at t+1, `inst_req` at t+2 at the earliest. `inst_req` is held in REQ until `inst_addr_ok`.
- Address error: no request. `exc_o`=1 on the next edge with `ready_i`.
- `ready_i`=0: no lookup starts and outputs hold. A request already stalled in REQ keeps `inst_req` low while `ready_i`=0.
- `commit_i` during QUERY/REQ: the refill is abandoned. `cancelled_o`=1 on the next edge with `ready_i`.

## Test plan
- Reset, then `pc_i`=0xBFC00000, `valid_i`=`ready_i`=1, `inst_addr_ok`=1 → same-cycle `inst_req`, `inst_addr`=0x1FC00000, `inst_cache`=0; next edge `valid_o`=1, `pc_o`=0xBFC00000.
- `pc_i`=0x00400004, TLB returns pfn 0x12345 with cattr=3 → `tlb_vaddr`=0x00400004 in QUERY; REQ `inst_addr`=0x12345004, `inst_cache`=1; refetch 0x00400008 hits with no QUERY, and `perfcnt_utlb_miss`=1.
- With `UTLB_ENTRIES`=4, touch 5 distinct pages, then the first page → 6 refills total; the first page has been evicted round-robin.
- `tlb_miss`=1 at 0x00800000 → `exc_o`=1, `exc_miss_o`=1, `exccode_o`=2, no `inst_req`; `pc_i`=0x00400002 → `exccode_o`=4.
- `tlb_write` pulse after a fill → next access to the same page re-queries. `commit_i` in REQ → CHECK next cycle and `cancelled_o`=1.
- Assert `resetn`=0 mid-REQ, asynchronously → outputs 0 immediately, qstate=CHECK, all entries invalid.
